gyro_filter_sequencer: RTL and testbench
========================================

Name: gyro_filter_sequencer

Overview:
- Time-multiplexed controller for the gyro high-pass FIR. Replaces three parallel 10-tap multiplier trees with one shared multiply-accumulate unit.
- Captures X/Y/Z gyro samples on each IMU read-complete strobe and updates the per-axis sample histories.
- Sequences 3×Taps MAC operations, then publishes all three filtered axes together with a one-cycle DataReady pulse.
- Sits between the IMU reader and the attitude/control logic, on the main system clock.

Parameters:
- Taps, 10, FIR length (number of history samples per axis).
- DataW, 10, sample and output width, signed two's complement.
- CoefW, 16, coefficient width, signed Q1.15.
- AccW, 30, accumulator width (DataW+CoefW+ceil(log2 Taps)).

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- SampleValid  in  1  one-cycle strobe: new GyroX/Y/Z valid (synchronized ReadDone).
- GyroX  in  DataW  X sample, signed.
- GyroY  in  DataW  Y sample, signed.
- GyroZ  in  DataW  Z sample, signed.
- ClearOverrun  in  1  clears sticky Overrun.
- GyroXOut  out  DataW  filtered X.
- GyroYOut  out  DataW  filtered Y.
- GyroZOut  out  DataW  filtered Z.
- DataReady  out  1  one-cycle pulse: outputs updated this cycle.
- Busy  out  1  high while not in IDLE.
- Primed  out  1  high once Taps samples have been accepted since reset.
- Overrun  out  1  sticky: SampleValid arrived while Busy.

Behaviour:
- Reset (async, Reset_n=0):
  - All outputs 0.
  - Histories and accumulator 0; prime counter 0.
  - State IDLE.
  - Reset mid-sequence aborts the sequence; no DataReady is produced.
- States: IDLE -> MAC -> DONE -> IDLE.
- IDLE:
  - On SampleValid: shift each axis history (hist[k] <= hist[k-1], hist[0] <= new sample).
  - Clear accumulator; axis=0, tap=0; go to MAC.
  - Prime counter increments, saturating at Taps; Primed = (count == Taps).
- MAC:
  - One product per cycle: acc += sext(hist_axis[tap]) * COEF[tap].
  - Tap is the inner loop 0..Taps-1; axis is the outer loop X, Y, Z.
  - When tap == Taps-1: write the scaled result into the holding register for that axis, clear acc, tap=0, axis++.
  - After Z: go to DONE.
- DONE:
  - GyroXOut/YOut/ZOut load simultaneously from the holding registers.
  - DataReady = 1 for exactly this cycle; then IDLE.
- Latency: SampleValid in cycle 0 -> DataReady in cycle 3*Taps+1 (31 at default). Busy high in cycles 1..31.
- Scaling: result = acc >>> 15 (arithmetic shift, floor), then truncated to the low DataW bits.
- Outputs hold their value between DataReady pulses.
- SampleValid while Busy:
  - Sample is dropped; histories untouched; Overrun <= 1.
  - SampleValid in the DONE cycle also counts as overrun.
- ClearOverrun and a new overrun in the same cycle: set wins.
- Before Primed, outputs are computed with zero-filled history (no suppression). Primed is informational only.
- Coefficients are constants; histories are not writable externally.

Optional Feature:
- Macro GYRO_FILTER_SATURATE_EN.
- Defined: the scaled result is clamped to [-2^(DataW-1), 2^(DataW-1)-1] (-512..511) before loading the output.
- Not defined: plain two's-complement truncation (wrap).
- Latency is identical in both cases.

Decomposition:
- Shared package gyro_filter_pkg holds:
  - The COEF array as a localparam of signed CoefW values: fda5, 0e32, d54b, 52ed, 8e58, 71a8, ad13, 2ab5, f1ce, 025b.
  - The Taps/DataW/CoefW/AccW defaults.
  - The state enum typedef {IDLE, MAC, DONE}.
  - The axis index typedef.
- One sub-module, gyro_mac_unit: signed multiply, accumulate, clear, and the scale/clamp logic.
- Sequencer FSM, histories and counters stay in gyro_filter_sequencer.

Test Plan:
- Reset mid-MAC: assert Reset_n=0 at cycle 10 after SampleValid -> all outputs 0, Busy=0, no DataReady; the next SampleValid gives a normal sequence.
- Impulse: X=256 once, then zeros -> successive GyroXOut = floor(COEF[k]*256/32768): -5, 28, -86, ... for k=0..9, then 0. Y/Z stay 0. DataReady exactly 31 cycles after each SampleValid.
- DC: X=Y=Z=100 for 12 samples -> after Primed=1, all outputs exactly 0 (coefficients sum to 0). Primed rises on the 10th accepted sample.
- Overrun: SampleValid again 5 cycles after the first -> second sample ignored and Overrun=1. ClearOverrun pulse -> 0. ClearOverrun coincident with a new overrun -> Overrun stays 1.
- Saturation: X alternating +511/-512 for 12 samples:
  - With GYRO_FILTER_SATURATE_EN: GyroXOut is -512 or +511 every output.
  - Without it: GyroXOut equals the low 10 bits of floor(acc/32768).
- Back-to-back: SampleValid every 32 cycles for 20 samples -> 20 DataReady pulses, Overrun stays 0.

Source files
------------

// File: rtl/gyro_filter_pkg.sv
// Shared constants, coefficient table and typedefs for the time-multiplexed gyro high-pass FIR.
package gyro_filter_pkg;

    localparam int unsigned Taps  = 10;
    localparam int unsigned DataW = 10;
    localparam int unsigned CoefW = 16;
    localparam int unsigned AccW  = 30;
    localparam int unsigned FracW = 15;
    localparam int unsigned TapW  = $clog2(Taps);
    localparam int unsigned CntW  = $clog2(Taps + 1);

    // High-pass taps in Q1.15; they sum to exactly zero so DC is fully rejected.
    localparam logic signed [CoefW-1:0] COEF [Taps] = '{
        16'shfda5, 16'sh0e32, 16'shd54b, 16'sh52ed, 16'sh8e58,
        16'sh71a8, 16'shad13, 16'sh2ab5, 16'shf1ce, 16'sh025b
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } seqState_t;

    typedef enum logic [1:0] {
        AXIS_X = 2'd0,
        AXIS_Y = 2'd1,
        AXIS_Z = 2'd2
    } axis_t;

endpackage

// File: rtl/gyro_mac_unit.sv
// Shared signed multiply-accumulate with Q1.15 rescale; GYRO_FILTER_SATURATE_EN clamps instead of wrapping.
module gyro_mac_unit
    import gyro_filter_pkg::*;
(
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic                    accEn,
    input  logic                    accClear,
    input  logic signed [DataW-1:0] sample,
    input  logic signed [CoefW-1:0] coef,
    output logic signed [DataW-1:0] scaled_c
);

    localparam int unsigned ProdW = DataW + CoefW;

    logic signed [ProdW-1:0] product;
    logic signed [AccW-1:0]  acc;
    logic signed [AccW-1:0]  accSum;

    assign product = ProdW'(sample) * ProdW'(coef);
    assign accSum  = acc + AccW'(product);

    // Clear has priority so the last tap of an axis can both publish and reset.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            acc <= '0;
        end else if (accClear) begin
            acc <= '0;
        end else if (accEn) begin
            acc <= accSum;
        end
    end

    // The result includes the product of the current cycle so the last tap needs no extra cycle.
`ifdef GYRO_FILTER_SATURATE_EN
    localparam logic signed [AccW-1:0] SatMax = AccW'(2 ** (DataW - 1) - 1);
    localparam logic signed [AccW-1:0] SatMin = ~SatMax;

    logic signed [AccW-1:0] shifted;

    assign shifted = accSum >>> FracW;

    always_comb begin
        scaled_c = shifted[DataW-1:0];
        if (shifted > SatMax) begin
            scaled_c = SatMax[DataW-1:0];
        end else if (shifted < SatMin) begin
            scaled_c = SatMin[DataW-1:0];
        end
    end
`else
    assign scaled_c = accSum[FracW +: DataW];
`endif

endmodule

// File: rtl/gyro_filter_sequencer.sv
// Gyro high-pass FIR sequencer: one shared MAC walks X/Y/Z histories, then publishes all axes at once.
// Optional GYRO_FILTER_SATURATE_EN clamps outputs to the DataW range instead of wrapping.
module gyro_filter_sequencer
    import gyro_filter_pkg::*;
(
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic                    SampleValid,
    input  logic signed [DataW-1:0] GyroX,
    input  logic signed [DataW-1:0] GyroY,
    input  logic signed [DataW-1:0] GyroZ,
    input  logic                    ClearOverrun,
    output logic signed [DataW-1:0] GyroXOut,
    output logic signed [DataW-1:0] GyroYOut,
    output logic signed [DataW-1:0] GyroZOut,
    output logic                    DataReady,
    output logic                    Busy,
    output logic                    Primed,
    output logic                    Overrun
);

    seqState_t               state;
    axis_t                   axis;
    logic [TapW-1:0]         tap;
    logic [CntW-1:0]         primeCnt;
    logic signed [DataW-1:0] histX [Taps];
    logic signed [DataW-1:0] histY [Taps];
    logic signed [DataW-1:0] histZ [Taps];
    logic signed [DataW-1:0] holdX;
    logic signed [DataW-1:0] holdY;

    logic                    accept;
    logic                    overrunSet;
    logic                    lastTap;
    logic                    accEn;
    logic                    accClear;
    logic signed [DataW-1:0] macSample;
    logic signed [CoefW-1:0] macCoef;
    logic signed [DataW-1:0] scaled;

    assign accept     = SampleValid && (state == IDLE);
    assign overrunSet = SampleValid && (state != IDLE);
    assign lastTap    = (tap == TapW'(Taps - 1));
    assign accEn      = (state == MAC);
    assign accClear   = accept || ((state == MAC) && lastTap);
    assign macCoef    = COEF[tap];

    always_comb begin
        macSample = '0;
        case (axis)
            AXIS_X:  macSample = histX[tap];
            AXIS_Y:  macSample = histY[tap];
            AXIS_Z:  macSample = histZ[tap];
            default: macSample = '0;
        endcase
    end

    gyro_mac_unit u_mac (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .accEn    (accEn),
        .accClear (accClear),
        .sample   (macSample),
        .coef     (macCoef),
        .scaled_c (scaled)
    );

    // Sequencer FSM, sample histories, prime counter and registered outputs.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            axis      <= AXIS_X;
            tap       <= '0;
            primeCnt  <= '0;
            holdX     <= '0;
            holdY     <= '0;
            GyroXOut  <= '0;
            GyroYOut  <= '0;
            GyroZOut  <= '0;
            DataReady <= 1'b0;
            Busy      <= 1'b0;
            Primed    <= 1'b0;
            Overrun   <= 1'b0;
            for (int unsigned k = 0; k < Taps; k++) begin
                histX[k] <= '0;
                histY[k] <= '0;
                histZ[k] <= '0;
            end
        end else begin
            DataReady <= 1'b0;

            // A new overrun outranks a simultaneous clear.
            if (overrunSet) begin
                Overrun <= 1'b1;
            end else if (ClearOverrun) begin
                Overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int unsigned k = Taps - 1; k > 0; k--) begin
                            histX[k] <= histX[k-1];
                            histY[k] <= histY[k-1];
                            histZ[k] <= histZ[k-1];
                        end
                        histX[0] <= GyroX;
                        histY[0] <= GyroY;
                        histZ[0] <= GyroZ;
                        if (primeCnt != CntW'(Taps)) begin
                            primeCnt <= primeCnt + CntW'(1);
                        end
                        Primed <= (primeCnt >= CntW'(Taps - 1));
                        axis   <= AXIS_X;
                        tap    <= '0;
                        Busy   <= 1'b1;
                        state  <= MAC;
                    end
                end

                MAC: begin
                    if (lastTap) begin
                        tap <= '0;
                        case (axis)
                            AXIS_X: begin
                                holdX <= scaled;
                                axis  <= AXIS_Y;
                            end
                            AXIS_Y: begin
                                holdY <= scaled;
                                axis  <= AXIS_Z;
                            end
                            default: begin
                                // Z finishes here; publish so outputs are valid during DONE.
                                GyroXOut  <= holdX;
                                GyroYOut  <= holdY;
                                GyroZOut  <= scaled;
                                DataReady <= 1'b1;
                                axis      <= AXIS_X;
                                state     <= DONE;
                            end
                        endcase
                    end else begin
                        tap <= tap + TapW'(1);
                    end
                end

                DONE: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gyro_filter_sequencer.sv
// Directed self-checking bench for gyro_filter_sequencer with hand-computed FIR results.
module tb_gyro_filter_sequencer;

    logic              Clock = 1'b0;
    logic              Reset_n = 1'b0;
    logic              SampleValid = 1'b0;
    logic signed [9:0] GyroX = '0;
    logic signed [9:0] GyroY = '0;
    logic signed [9:0] GyroZ = '0;
    logic              ClearOverrun = 1'b0;
    logic signed [9:0] GyroXOut;
    logic signed [9:0] GyroYOut;
    logic signed [9:0] GyroZOut;
    logic              DataReady;
    logic              Busy;
    logic              Primed;
    logic              Overrun;

    int nCompared = 0;
    int nMismatched = 0;

    always #5 Clock = ~Clock;

    gyro_filter_sequencer dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .SampleValid  (SampleValid),
        .GyroX        (GyroX),
        .GyroY        (GyroY),
        .GyroZ        (GyroZ),
        .ClearOverrun (ClearOverrun),
        .GyroXOut     (GyroXOut),
        .GyroYOut     (GyroYOut),
        .GyroZOut     (GyroZOut),
        .DataReady    (DataReady),
        .Busy         (Busy),
        .Primed       (Primed),
        .Overrun      (Overrun)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic applyReset();
        SampleValid  = 1'b0;
        ClearOverrun = 1'b0;
        GyroX = '0; GyroY = '0; GyroZ = '0;
        Reset_n = 1'b0;
        #7;
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic sendSample(input int x, input int y, input int z);
        GyroX = 10'(x); GyroY = 10'(y); GyroZ = 10'(z);
        SampleValid = 1'b1;
        tick();
        SampleValid = 1'b0;
        GyroX = '0; GyroY = '0; GyroZ = '0;
    endtask

    // Returns the cycle index (SampleValid cycle = 0) at which DataReady is seen; 100 on timeout.
    task automatic waitReady(output int lat);
        lat = 1;
        while (DataReady !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        int lat;
        int pulses;
        Reset_n = 1'b0;
        #2;
        nCompared++;
        if ({GyroXOut, GyroYOut, GyroZOut, DataReady, Busy, Primed, Overrun} !== 34'd0) begin
            nMismatched++;
            $display("FAIL reset_outputs: got %h want 0", {GyroXOut, GyroYOut, GyroZOut, DataReady, Busy, Primed, Overrun});
        end
        applyReset();
        sendSample(256, 0, 0);
        waitReady(lat);
        nCompared++;
        if (GyroXOut !== -10'sd5) begin
            nMismatched++;
            $display("FAIL reset_pre_x: got %0d want -5", GyroXOut);
        end
        tick();
        sendSample(0, 0, 0);
        repeat (9) tick();
        nCompared++;
        if (Busy !== 1'b1) begin
            nMismatched++;
            $display("FAIL reset_busy_mid: got %b want 1", Busy);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        nCompared++;
        if ({GyroXOut, GyroYOut, GyroZOut, DataReady, Busy, Primed, Overrun} !== 34'd0) begin
            nMismatched++;
            $display("FAIL reset_mid_outputs: got %h want 0", {GyroXOut, GyroYOut, GyroZOut, DataReady, Busy, Primed, Overrun});
        end
        pulses = 0;
        repeat (3) begin
            tick();
            if (DataReady === 1'b1) pulses++;
        end
        Reset_n = 1'b1;
        repeat (40) begin
            tick();
            if (DataReady === 1'b1) pulses++;
        end
        nCompared++;
        if (pulses !== 0) begin
            nMismatched++;
            $display("FAIL reset_no_ready: got %0d pulses want 0", pulses);
        end
        sendSample(256, 0, 0);
        waitReady(lat);
        nCompared++;
        if (lat !== 31) begin
            nMismatched++;
            $display("FAIL reset_after_latency: got %0d want 31", lat);
        end
        nCompared++;
        if (GyroXOut !== -10'sd5) begin
            nMismatched++;
            $display("FAIL reset_after_x: got %0d want -5", GyroXOut);
        end
        tick();
    endtask

    task automatic test_impulse();
        int lat;
        int impExp[11] = '{-5, 28, -86, 165, -228, 227, -166, 85, -29, 4, 0};
        applyReset();
        for (int i = 0; i < 11; i++) begin
            sendSample((i == 0) ? 256 : 0, 0, 0);
            waitReady(lat);
            nCompared++;
            if (lat !== 31) begin
                nMismatched++;
                $display("FAIL impulse_latency[%0d]: got %0d want 31", i, lat);
            end
            nCompared++;
            if (GyroXOut !== 10'(impExp[i])) begin
                nMismatched++;
                $display("FAIL impulse_x[%0d]: got %0d want %0d", i, GyroXOut, impExp[i]);
            end
            nCompared++;
            if (GyroYOut !== 10'sd0 || GyroZOut !== 10'sd0) begin
                nMismatched++;
                $display("FAIL impulse_yz[%0d]: got %0d/%0d want 0/0", i, GyroYOut, GyroZOut);
            end
            tick();
            nCompared++;
            if (DataReady !== 1'b0 || Busy !== 1'b0) begin
                nMismatched++;
                $display("FAIL impulse_pulse_end[%0d]: got ready=%b busy=%b want 0/0", i, DataReady, Busy);
            end
        end
    endtask

    task automatic test_dc();
        int lat;
        applyReset();
        for (int n = 1; n <= 12; n++) begin
            sendSample(100, 100, 100);
            waitReady(lat);
            nCompared++;
            if (Primed !== (n >= 10)) begin
                nMismatched++;
                $display("FAIL dc_primed[%0d]: got %b want %b", n, Primed, (n >= 10));
            end
            if (n == 1) begin
                nCompared++;
                if (GyroXOut !== -10'sd2 || GyroYOut !== -10'sd2 || GyroZOut !== -10'sd2) begin
                    nMismatched++;
                    $display("FAIL dc_first: got %0d/%0d/%0d want -2/-2/-2", GyroXOut, GyroYOut, GyroZOut);
                end
            end
            if (n >= 10) begin
                nCompared++;
                if (GyroXOut !== 10'sd0 || GyroYOut !== 10'sd0 || GyroZOut !== 10'sd0) begin
                    nMismatched++;
                    $display("FAIL dc_zero[%0d]: got %0d/%0d/%0d want 0/0/0", n, GyroXOut, GyroYOut, GyroZOut);
                end
            end
            tick();
        end
    endtask

    task automatic test_overrun();
        int lat;
        applyReset();
        sendSample(256, 0, 0);
        repeat (4) tick();
        GyroX = 10'sd300;
        SampleValid = 1'b1;
        tick();
        SampleValid = 1'b0;
        GyroX = '0;
        waitReady(lat);
        nCompared++;
        if (GyroXOut !== -10'sd5 || Overrun !== 1'b1) begin
            nMismatched++;
            $display("FAIL overrun_drop: got x=%0d ovr=%b want -5/1", GyroXOut, Overrun);
        end
        tick();
        sendSample(0, 0, 0);
        waitReady(lat);
        nCompared++;
        if (GyroXOut !== 10'sd28) begin
            nMismatched++;
            $display("FAIL overrun_history: got %0d want 28", GyroXOut);
        end
        tick();
        ClearOverrun = 1'b1;
        tick();
        ClearOverrun = 1'b0;
        nCompared++;
        if (Overrun !== 1'b0) begin
            nMismatched++;
            $display("FAIL overrun_clear: got %b want 0", Overrun);
        end
        sendSample(0, 0, 0);
        repeat (3) tick();
        GyroX = 10'sd300;
        SampleValid = 1'b1;
        ClearOverrun = 1'b1;
        tick();
        SampleValid = 1'b0;
        ClearOverrun = 1'b0;
        GyroX = '0;
        nCompared++;
        if (Overrun !== 1'b1) begin
            nMismatched++;
            $display("FAIL overrun_set_wins: got %b want 1", Overrun);
        end
        waitReady(lat);
        nCompared++;
        if (GyroXOut !== -10'sd86) begin
            nMismatched++;
            $display("FAIL overrun_history2: got %0d want -86", GyroXOut);
        end
        tick();
        ClearOverrun = 1'b1;
        tick();
        ClearOverrun = 1'b0;
        sendSample(0, 0, 0);
        waitReady(lat);
        nCompared++;
        if (GyroXOut !== 10'sd165 || Overrun !== 1'b0) begin
            nMismatched++;
            $display("FAIL overrun_pre_done: got x=%0d ovr=%b want 165/0", GyroXOut, Overrun);
        end
        GyroX = 10'sd300;
        SampleValid = 1'b1;
        tick();
        SampleValid = 1'b0;
        GyroX = '0;
        nCompared++;
        if (Overrun !== 1'b1 || Busy !== 1'b0) begin
            nMismatched++;
            $display("FAIL overrun_done_cycle: got ovr=%b busy=%b want 1/0", Overrun, Busy);
        end
        sendSample(0, 0, 0);
        waitReady(lat);
        nCompared++;
        if (GyroXOut !== -10'sd228) begin
            nMismatched++;
            $display("FAIL overrun_history3: got %0d want -228", GyroXOut);
        end
        tick();
    endtask

    task automatic test_saturate();
        int lat;
        int expX;
        bit checkIt;
        applyReset();
        for (int n = 0; n < 12; n++) begin
            sendSample((n % 2 == 0) ? 511 : -512, 0, 0);
            waitReady(lat);
            checkIt = 1'b1;
            expX = 0;
            case (n)
                0: expX = -10;
                1: expX = 66;
                2: expX = -237;
`ifdef GYRO_FILTER_SATURATE_EN
                9, 11: expX = 511;
                10:    expX = -512;
`else
                9, 11: expX = -4;
                10:    expX = 3;
`endif
                default: checkIt = 1'b0;
            endcase
            if (checkIt) begin
                nCompared++;
                if (GyroXOut !== 10'(expX)) begin
                    nMismatched++;
                    $display("FAIL saturate_x[%0d]: got %0d want %0d", n, GyroXOut, expX);
                end
            end
            tick();
        end
        nCompared++;
        if (GyroYOut !== 10'sd0 || GyroZOut !== 10'sd0) begin
            nMismatched++;
            $display("FAIL saturate_yz: got %0d/%0d want 0/0", GyroYOut, GyroZOut);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        applyReset();
        for (int i = 0; i < 20; i++) begin
            GyroX = 10'sd100; GyroY = 10'sd100; GyroZ = 10'sd100;
            SampleValid = 1'b1;
            if (DataReady === 1'b1) pulses++;
            tick();
            SampleValid = 1'b0;
            repeat (31) begin
                if (DataReady === 1'b1) pulses++;
                tick();
            end
        end
        nCompared++;
        if (pulses !== 20) begin
            nMismatched++;
            $display("FAIL b2b_pulses: got %0d want 20", pulses);
        end
        nCompared++;
        if (Overrun !== 1'b0) begin
            nMismatched++;
            $display("FAIL b2b_overrun: got %b want 0", Overrun);
        end
        nCompared++;
        if (GyroXOut !== 10'sd0 || GyroYOut !== 10'sd0 || GyroZOut !== 10'sd0 || Primed !== 1'b1) begin
            nMismatched++;
            $display("FAIL b2b_final: got %0d/%0d/%0d primed=%b want 0/0/0/1", GyroXOut, GyroYOut, GyroZOut, Primed);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_overrun();
        test_saturate();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
